// File: rtl/eth_parser_pkg.sv
// eth_parser_pkg
//   Shared types for the Ethernet parser datapath.
//   eth_metadata_t : per-frame metadata produced by metadata_packager
//   egress_state_e : frame-position state of the egress stage
package eth_parser_pkg;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic        vlan_valid;
        logic [11:0] vlan_id;
        logic [15:0] frame_len;
    } eth_metadata_t;

    typedef enum logic {
        EG_IDLE   = 1'b0,
        EG_ACTIVE = 1'b1
    } egress_state_e;

endpackage

// File: rtl/axis_egress_meta_q_skid.sv
// axis_skid_buf
//   Two-entry registered slice for an AXI-stream payload (tdata/tkeep/tlast).
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     i_tdata/i_tkeep/i_tlast/i_tvalid, o_tready   upstream side
//     o_tdata/o_tkeep/o_tlast/o_tvalid             head of buffer
//     i_pop                 head consumed this cycle (downstream accept)
module axis_skid_buf #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   i_tdata,
    input  logic [DATA_WIDTH/8-1:0] i_tkeep,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    o_tready,
    output logic [DATA_WIDTH-1:0]   o_tdata,
    output logic [DATA_WIDTH/8-1:0] o_tkeep,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    i_pop
);

    logic [DATA_WIDTH-1:0]   r_data [2];
    logic [DATA_WIDTH/8-1:0] r_keep [2];
    logic                    r_last [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;
    logic                    r_ready;

    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count_nxt;

    assign w_push      = i_tvalid & r_ready;
    assign w_pop       = i_pop & (r_count != 2'd0);
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // Ready is registered from the next occupancy so it is a pure flop output
    // yet still reflects a pop happening in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_keep[i] <= '0;
                r_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= i_tdata;
                r_keep[r_wr_ptr] <= i_tkeep;
                r_last[r_wr_ptr] <= i_tlast;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != 2'd2);
        end
    end

    assign o_tready = r_ready;
    assign o_tvalid = (r_count != 2'd0);
    assign o_tdata  = r_data[r_rd_ptr];
    assign o_tkeep  = r_keep[r_rd_ptr];
    assign o_tlast  = r_last[r_rd_ptr];

endmodule

// File: rtl/axis_egress_meta_q.sv
// axis_egress_meta_q
//   AXI-stream egress stage: payload through a 2-entry skid buffer, per-frame
//   metadata through a META_DEPTH FIFO whose head is presented with every beat
//   of the frame it belongs to.
//   Ports:
//     clk, rst_n                       clock, asynchronous active-low reset
//     s_axis_*                         payload input (tready registered)
//     m_axis_*                         payload output
//     metadata_in/metadata_valid_in    metadata push
//     meta_full                        FIFO full (registered)
//     metadata_out/metadata_valid_out  FIFO head and non-empty flag
//     frame_count, meta_miss_count     statistics counters (wrap)
//     meta_overflow                    sticky: push dropped on full FIFO
//     clear_stats                      synchronous clear of statistics
module axis_egress_meta_q
    import eth_parser_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int META_DEPTH   = 4,
    parameter bit GATE_ON_META = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    input  eth_metadata_t           metadata_in,
    input  logic                    metadata_valid_in,
    output logic                    meta_full,
    output eth_metadata_t           metadata_out,
    output logic                    metadata_valid_out,
    output logic [CNT_W-1:0]        frame_count,
    output logic [CNT_W-1:0]        meta_miss_count,
    output logic                    meta_overflow,
    input  logic                    clear_stats
);

    localparam int PW = $clog2(META_DEPTH);
    localparam int QW = PW + 1;

    logic w_buf_valid;
    logic w_gate;
    logic w_accept;

    axis_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_tdata (s_axis_tdata),
        .i_tkeep (s_axis_tkeep),
        .i_tlast (s_axis_tlast),
        .i_tvalid(s_axis_tvalid),
        .o_tready(s_axis_tready),
        .o_tdata (m_axis_tdata),
        .o_tkeep (m_axis_tkeep),
        .o_tlast (m_axis_tlast),
        .o_tvalid(w_buf_valid),
        .i_pop   (w_accept)
    );

    eth_metadata_t  r_meta_mem [META_DEPTH];
    logic [PW-1:0]  r_meta_wr;
    logic [PW-1:0]  r_meta_rd;
    logic [QW-1:0]  r_meta_cnt;
    logic           r_meta_full;
    egress_state_e  r_state;
    logic [CNT_W-1:0] r_frame_count;
    logic [CNT_W-1:0] r_miss_count;
    logic           r_overflow;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_miss;
    logic [QW-1:0] w_meta_cnt_nxt;

    assign w_empty = (r_meta_cnt == '0);

    // The gate is only consulted in IDLE; once a frame is in flight the FIFO
    // head cannot be popped before its tlast, so tvalid never retracts.
    assign w_gate        = !GATE_ON_META || (r_state == EG_ACTIVE) || !w_empty;
    assign m_axis_tvalid = w_buf_valid & w_gate;
    assign w_accept      = m_axis_tvalid & m_axis_tready;

    // A pop frees a slot in the same cycle, so a push on a full FIFO is taken.
    assign w_pop          = w_accept & m_axis_tlast & !w_empty;
    assign w_push         = metadata_valid_in & (!r_meta_full | w_pop);
    assign w_drop         = metadata_valid_in & r_meta_full & !w_pop;
    assign w_miss         = !GATE_ON_META & w_accept & (r_state == EG_IDLE) & w_empty;
    assign w_meta_cnt_nxt = r_meta_cnt + QW'(w_push) - QW'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < META_DEPTH; i++) begin
                r_meta_mem[i] <= '0;
            end
            r_meta_wr     <= '0;
            r_meta_rd     <= '0;
            r_meta_cnt    <= '0;
            r_meta_full   <= 1'b0;
            r_state       <= EG_IDLE;
            r_frame_count <= '0;
            r_miss_count  <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push) begin
                r_meta_mem[r_meta_wr] <= metadata_in;
                r_meta_wr             <= r_meta_wr + 1'b1;
            end
            if (w_pop) begin
                r_meta_rd <= r_meta_rd + 1'b1;
            end
            r_meta_cnt  <= w_meta_cnt_nxt;
            r_meta_full <= (w_meta_cnt_nxt == QW'(META_DEPTH));

            if (w_accept) begin
                r_state <= m_axis_tlast ? EG_IDLE : EG_ACTIVE;
            end

            if (clear_stats) begin
                r_frame_count <= '0;
                r_miss_count  <= '0;
                r_overflow    <= 1'b0;
            end else begin
                if (w_accept && m_axis_tlast) r_frame_count <= r_frame_count + CNT_W'(1);
                if (w_miss)                   r_miss_count  <= r_miss_count + CNT_W'(1);
                if (w_drop)                   r_overflow    <= 1'b1;
            end
        end
    end

    assign meta_full          = r_meta_full;
    assign metadata_out       = r_meta_mem[r_meta_rd];
    assign metadata_valid_out = !w_empty;
    assign frame_count        = r_frame_count;
    assign meta_miss_count    = r_miss_count;
    assign meta_overflow      = r_overflow;

endmodule
